spi_peripheral: RTL

// - SPI write-only register-file slave. Feeds the PWM stage: holds output-enable, PWM-enable and duty-cycle registers.
// - Samples the external sCLK/nCS/COPI pins in the system clk domain. Decodes 16-bit write frames. Updates one register per valid frame.
// - Outputs drive pwm_peripheral directly. Each register value is stable except for a single-cycle update.

---
 rtl/spi_peripheral.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// rtl/spi_peripheral.sv - SPI write-only register file feeding the PWM stage
// Pins are synchronised into clk; 16-bit frames {w, addr[6:0], data[7:0]} update one register on nCS rise.
module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sCLK,
    input  logic       nCS,
    input  logic       COPI,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] ncs_sr;
    logic [SYNC_STAGES-1:0] copi_sr;
    logic                   sclk_hist;
    logic                   ncs_hist;

    logic sclk_s;
    logic ncs_s;
    logic copi_s;
    logic sclk_rise;
    logic ncs_fall;
    logic ncs_rise;

    state_t      state;
    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        frame_ok;

    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign ncs_s  = ncs_sr[SYNC_STAGES-1];
    assign copi_s = copi_sr[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist;
    assign ncs_fall  = ~ncs_s & ncs_hist;
    assign ncs_rise  = ncs_s & ~ncs_hist;

    assign frame_ok = (bit_cnt == 5'd16) && shift_reg[15] && (shift_reg[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sr   <= '0;
            ncs_sr    <= '0;
            copi_sr   <= '0;
            sclk_hist <= 1'b0;
            ncs_hist  <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sCLK};
            ncs_sr    <= {ncs_sr[SYNC_STAGES-2:0], nCS};
            copi_sr   <= {copi_sr[SYNC_STAGES-2:0], COPI};
            sclk_hist <= sclk_s;
            ncs_hist  <= ncs_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            shift_reg       <= '0;
            bit_cnt         <= '0;
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    // nCS rise wins over a coincident sCLK edge; the master owes us hold time.
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[14:0], copi_s};
                        if (bit_cnt != 5'd17) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (frame_ok) begin
                        case (shift_reg[14:8])
                            7'h00:   en_reg_out_7_0  <= shift_reg[7:0];
                            7'h01:   en_reg_out_15_8 <= shift_reg[7:0];
                            7'h02:   en_reg_pwm_7_0  <= shift_reg[7:0];
                            7'h03:   en_reg_pwm_15_8 <= shift_reg[7:0];
                            7'h04:   pwm_duty_cycle  <= shift_reg[7:0];
                            default: ;
                        endcase
                    end
                    if (ncs_fall) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
